mcdf_ctrl_regs_p: RTL and testbench

Parametrised successor of the MCDF control register bank: one 32-bit command port configures N slave channels (enable, priority, packet length), exposes each channel's FIFO margin read-only, and adds a margin-threshold interrupt with sticky W1C status plus a one-way configuration lock. It sits between the MCDF command interface and the slave channels/arbiter/formatter.

---
 rtl/mcdf_ctrl_pkg.sv | 70 +++++++
 rtl/mcdf_ctrl_chan.sv | 50 +++++
 rtl/mcdf_ctrl_regs_p.sv | 127 ++++++++++++
 tb/tb_mcdf_ctrl_regs_p.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdf_ctrl_pkg.sv
// Shared definitions for the MCDF control register bank: command encodings,
// register map, CTRL field layout and the address decoder.
package mcdf_ctrl_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam logic [7:0] CTRL_BASE     = 8'h00;
  localparam logic [7:0] STAT_BASE     = 8'h20;
  localparam logic [7:0] THRESH_ADDR   = 8'h40;
  localparam logic [7:0] IRQ_STAT_ADDR = 8'h44;
  localparam logic [7:0] LOCK_ADDR     = 8'h48;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_PRIO_LSB   = 1;
  localparam int CTRL_PKGLEN_LSB = 3;
  localparam int CTRL_IRQEN_BIT  = 6;
  localparam int CTRL_W          = 7;

  localparam logic [CTRL_W-1:0] CTRL_RST = 7'h07;

  typedef struct packed {
    logic       irq_en;
    logic [2:0] pkglen;
    logic [1:0] prio;
    logic       en;
  } ctrl_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STAT,
    SEL_THRESH,
    SEL_IRQ,
    SEL_LOCK
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] idx;
  } addr_dec_t;

  // Maps a byte address to a register; SEL_NONE marks unaligned, unmapped,
  // or per-channel slots beyond the instantiated channel count.
  function automatic addr_dec_t decode_addr(input logic [7:0] addr, input int num_ch);
    addr_dec_t  d;
    logic [7:0] ofs;
    ofs   = addr - CTRL_BASE;
    d.sel = SEL_NONE;
    d.idx = ofs[4:2];
    if (ofs[1:0] == 2'b00) begin
      if (ofs < (STAT_BASE - CTRL_BASE)) begin
        if (int'(d.idx) < num_ch) d.sel = SEL_CTRL;
      end else if (addr >= STAT_BASE && addr < THRESH_ADDR) begin
        if (int'(d.idx) < num_ch) d.sel = SEL_STAT;
      end else begin
        case (addr)
          THRESH_ADDR:   d.sel = SEL_THRESH;
          IRQ_STAT_ADDR: d.sel = SEL_IRQ;
          LOCK_ADDR:     d.sel = SEL_LOCK;
          default:       d.sel = SEL_NONE;
        endcase
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/mcdf_ctrl_chan.sv
// One slave channel: its CTRL register and the sticky margin-threshold flag.
module mcdf_ctrl_chan
  import mcdf_ctrl_pkg::*;
#(
  parameter int MARGIN_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_ctrl_we,
  input  logic [CTRL_W-1:0]   i_wdata,
  input  logic                i_lock,
  input  logic                i_flag_clr,
  input  logic [MARGIN_W-1:0] i_thresh,
  input  logic [MARGIN_W-1:0] i_margin,
  output ctrl_t               o_ctrl,
  output logic                o_flag
);

  ctrl_t r_ctrl;
  logic  r_flag;
  logic  w_set;

  assign w_set = r_ctrl.en && (i_margin <= i_thresh);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and the async reset sits in the sensitivity list.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ctrl <= ctrl_t'(CTRL_RST);
    end else if (i_ctrl_we && !i_lock) begin
      r_ctrl.en     <= i_wdata[CTRL_EN_BIT];
      r_ctrl.prio   <= i_wdata[CTRL_PRIO_LSB +: 2];
      r_ctrl.pkglen <= i_wdata[CTRL_PKGLEN_LSB +: 3];
      r_ctrl.irq_en <= i_wdata[CTRL_IRQEN_BIT];
    end
  end

  // A new set on the same edge as a W1C clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flag <= 1'b0;
    end else begin
      r_flag <= w_set | (r_flag & ~i_flag_clr);
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_flag = r_flag;

endmodule

// File: rtl/mcdf_ctrl_regs_p.sv
// MCDF control register bank: command decode, THRESH/LOCK registers, read mux,
// error pulse and interrupt combine around NUM_CH channel register slices.
module mcdf_ctrl_regs_p
  import mcdf_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int MARGIN_W = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 cmd_i,
  input  logic [7:0]                 cmd_addr_i,
  input  logic [31:0]                cmd_data_i,
  input  logic [NUM_CH*MARGIN_W-1:0] slv_margin_i,
  output logic [31:0]                cmd_data_o,
  output logic                       cmd_err_o,
  output logic [NUM_CH-1:0]          slv_en_o,
  output logic [2*NUM_CH-1:0]        slv_prio_o,
  output logic [3*NUM_CH-1:0]        slv_pkglen_o,
  output logic                       irq_o
);

  addr_dec_t w_dec;
  logic      w_is_rd;
  logic      w_is_wr;
  logic      w_err;
  logic      w_rd_ok;
  logic      w_wr_ok;
  logic      w_locked_target;

  logic [MARGIN_W-1:0] r_thresh;
  logic                r_lock;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         w_rdata;

  ctrl_t               w_ctrl [NUM_CH];
  logic [NUM_CH-1:0]   w_flags;
  logic [NUM_CH-1:0]   w_ctrl_we;
  logic [NUM_CH-1:0]   w_flag_clr;
  logic [NUM_CH-1:0]   w_irq_src;
  logic                w_unused_data;

  assign w_dec   = decode_addr(cmd_addr_i, NUM_CH);
  assign w_is_rd = (cmd_i == CMD_READ);
  assign w_is_wr = (cmd_i == CMD_WRITE);

  assign w_locked_target = (w_dec.sel == SEL_CTRL) || (w_dec.sel == SEL_THRESH);

  assign w_err = (cmd_i == CMD_RSVD)
              || ((cmd_i != CMD_IDLE) && (w_dec.sel == SEL_NONE))
              || (w_is_wr && (w_dec.sel == SEL_STAT))
              || (w_is_wr && r_lock && w_locked_target);

  assign w_rd_ok = w_is_rd && !w_err;
  assign w_wr_ok = w_is_wr && !w_err;

  // Upper write-data bits carry no register field.
  assign w_unused_data = &{1'b0, cmd_data_i[31:CTRL_W]};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign w_ctrl_we[k]  = w_wr_ok && (w_dec.sel == SEL_CTRL) && (w_dec.idx == 3'(k));
    assign w_flag_clr[k] = w_wr_ok && (w_dec.sel == SEL_IRQ) && cmd_data_i[k];

    mcdf_ctrl_chan #(
      .MARGIN_W (MARGIN_W)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_ctrl_we  (w_ctrl_we[k]),
      .i_wdata    (cmd_data_i[CTRL_W-1:0]),
      .i_lock     (r_lock),
      .i_flag_clr (w_flag_clr[k]),
      .i_thresh   (r_thresh),
      .i_margin   (slv_margin_i[k*MARGIN_W +: MARGIN_W]),
      .o_ctrl     (w_ctrl[k]),
      .o_flag     (w_flags[k])
    );

    assign slv_en_o[k]          = w_ctrl[k].en;
    assign slv_prio_o[2*k +: 2] = w_ctrl[k].prio;
    assign slv_pkglen_o[3*k +: 3] = w_ctrl[k].pkglen;
    assign w_irq_src[k]         = w_flags[k] & w_ctrl[k].irq_en;
  end

  // NOTE: w_rdata gets a full default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    case (w_dec.sel)
      SEL_CTRL: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (w_dec.idx == 3'(k)) w_rdata[CTRL_W-1:0] = w_ctrl[k];
        end
      end
      SEL_STAT: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (w_dec.idx == 3'(k)) w_rdata[MARGIN_W-1:0] = slv_margin_i[k*MARGIN_W +: MARGIN_W];
        end
      end
      SEL_THRESH: w_rdata[MARGIN_W-1:0] = r_thresh;
      SEL_IRQ:    w_rdata[NUM_CH-1:0]   = w_flags;
      SEL_LOCK:   w_rdata[0]            = r_lock;
      default:    w_rdata               = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_thresh <= '0;
      r_lock   <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_rd_ok) r_rdata <= w_rdata;
      if (w_wr_ok && (w_dec.sel == SEL_THRESH)) r_thresh <= cmd_data_i[MARGIN_W-1:0];
      // LOCK is one-way: only reset returns it to zero.
      if (w_wr_ok && (w_dec.sel == SEL_LOCK) && cmd_data_i[0]) r_lock <= 1'b1;
    end
  end

  assign cmd_data_o = r_rdata;
  assign cmd_err_o  = r_err;
  assign irq_o      = |w_irq_src;

endmodule

// File: tb/tb_mcdf_ctrl_regs_p.sv
// Self-checking bench for mcdf_ctrl_regs_p: directed scenarios plus randomized
// command traffic compared against a register-map level reference model.
module tb_mcdf_ctrl_regs_p;

  localparam int NUM_CH = 3;
  localparam int MW     = 6;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic [1:0]             cmd_i;
  logic [7:0]             cmd_addr_i;
  logic [31:0]            cmd_data_i;
  logic [NUM_CH*MW-1:0]   slv_margin_i;
  logic [31:0]            cmd_data_o;
  logic                   cmd_err_o;
  logic [NUM_CH-1:0]      slv_en_o;
  logic [2*NUM_CH-1:0]    slv_prio_o;
  logic [3*NUM_CH-1:0]    slv_pkglen_o;
  logic                   irq_o;

  mcdf_ctrl_regs_p #(
    .NUM_CH   (NUM_CH),
    .MARGIN_W (MW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_i        (cmd_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .slv_margin_i (slv_margin_i),
    .cmd_data_o   (cmd_data_o),
    .cmd_err_o    (cmd_err_o),
    .slv_en_o     (slv_en_o),
    .slv_prio_o   (slv_prio_o),
    .slv_pkglen_o (slv_pkglen_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, kept as plain register-map values.
  logic [6:0]        m_ctrl [NUM_CH];
  logic [MW-1:0]     m_thresh;
  logic [NUM_CH-1:0] m_irq;
  bit                m_lock;
  logic [31:0]       m_data;
  bit                m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_ctrl[k] = 7'h07;
    m_thresh = '0;
    m_irq    = '0;
    m_lock   = 1'b0;
    m_data   = '0;
    m_err    = 1'b0;
  endtask

  task automatic set_margin(input int k, input int v);
    slv_margin_i[k*MW +: MW] = MW'(v);
  endtask

  function automatic int margin_of(input int k);
    return int'(slv_margin_i[k*MW +: MW]);
  endfunction

  task automatic check_outputs(input string tag);
    logic [NUM_CH-1:0]   e_en;
    logic [2*NUM_CH-1:0] e_prio;
    logic [3*NUM_CH-1:0] e_len;
    logic                e_irq;
    e_irq = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      e_en[k]          = m_ctrl[k][0];
      e_prio[2*k +: 2] = m_ctrl[k][2:1];
      e_len[3*k +: 3]  = m_ctrl[k][5:3];
      e_irq            = e_irq | (m_irq[k] & m_ctrl[k][6]);
    end
    check($sformatf("%s.data", tag), cmd_data_o, m_data);
    check($sformatf("%s.err", tag),  32'(cmd_err_o), 32'(m_err));
    check($sformatf("%s.en", tag),   32'(slv_en_o), 32'(e_en));
    check($sformatf("%s.prio", tag), 32'(slv_prio_o), 32'(e_prio));
    check($sformatf("%s.len", tag),  32'(slv_pkglen_o), 32'(e_len));
    check($sformatf("%s.irq", tag),  32'(irq_o), 32'(e_irq));
  endtask

  // Drive one command for one clock edge, advance the model, compare outputs.
  task automatic step(input logic [1:0] cmd, input logic [7:0] addr,
                      input logic [31:0] data, input string tag);
    int                a;
    int                kind;   // 0 none, 1 ctrl, 2 stat, 3 thresh, 4 irq, 5 lock
    int                idx;
    bit                err;
    logic [31:0]       rv;
    logic [NUM_CH-1:0] nirq;
    bit                set_k;
    bit                clr_k;

    cmd_i      = cmd;
    cmd_addr_i = addr;
    cmd_data_i = data;

    a    = int'(addr);
    kind = 0;
    idx  = 0;
    if (a % 4 == 0) begin
      if (a < 32) begin
        idx = a / 4;
        if (idx < NUM_CH) kind = 1;
      end else if (a < 64) begin
        idx = (a - 32) / 4;
        if (idx < NUM_CH) kind = 2;
      end else if (a == 64) kind = 3;
      else if (a == 68) kind = 4;
      else if (a == 72) kind = 5;
    end

    err = (cmd == 2'b11) || (cmd != 2'b00 && kind == 0) || (cmd == 2'b10 && kind == 2)
       || (cmd == 2'b10 && m_lock && (kind == 1 || kind == 3));

    rv = '0;
    case (kind)
      1: rv = 32'(m_ctrl[idx]);
      2: rv = 32'(margin_of(idx));
      3: rv = 32'(m_thresh);
      4: rv = 32'(m_irq);
      5: rv = 32'(m_lock);
      default: rv = '0;
    endcase

    for (int k = 0; k < NUM_CH; k++) begin
      set_k   = m_ctrl[k][0] && (margin_of(k) <= int'(m_thresh));
      clr_k   = (cmd == 2'b10) && !err && (kind == 4) && data[k];
      nirq[k] = set_k || (m_irq[k] && !clr_k);
    end

    @(posedge clk_i);
    m_err = err;
    if (cmd == 2'b01 && !err) m_data = rv;
    if (cmd == 2'b10 && !err) begin
      if (kind == 1) m_ctrl[idx] = data[6:0];
      if (kind == 3) m_thresh = data[MW-1:0];
      if (kind == 5 && data[0]) m_lock = 1'b1;
    end
    m_irq = nirq;

    @(negedge clk_i);
    check_outputs(tag);
  endtask

  task automatic rand_phase(input int n, input bit allow_lock);
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    int          r;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 3) == 0) set_margin(k, $urandom_range(0, 63));
      end
      r   = $urandom_range(0, 9);
      cmd = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      r   = $urandom_range(0, 19);
      if (r < 8)        addr = 8'(4 * r);
      else if (r < 16)  addr = 8'(32 + 4 * (r - 8));
      else if (r == 16) addr = 8'h40;
      else if (r == 17) addr = 8'h44;
      else if (r == 18) addr = 8'h48;
      else              addr = 8'($urandom_range(0, 255));
      data = $urandom;
      if (addr == 8'h48 && !allow_lock) data[0] = 1'b0;
      step(cmd, addr, data, "rand");
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    cmd_i        = 2'b00;
    cmd_addr_i   = '0;
    cmd_data_i   = '0;
    slv_margin_i = '1;
    set_margin(1, 33);
    model_reset();

    repeat (2) @(negedge clk_i);
    check_outputs("reset");
    rst_i = 1'b0;

    // Reset readback
    step(2'b01, 8'h00, 0, "rd_ctrl0");  check("ctrl0_rst", cmd_data_o, 32'h07);
    step(2'b01, 8'h04, 0, "rd_ctrl1");  check("ctrl1_rst", cmd_data_o, 32'h07);
    step(2'b01, 8'h08, 0, "rd_ctrl2");  check("ctrl2_rst", cmd_data_o, 32'h07);
    step(2'b01, 8'h24, 0, "rd_stat1");  check("stat1",     cmd_data_o, 32'h21);
    check("en_rst",   32'(slv_en_o),   32'h7);
    check("prio_rst", 32'(slv_prio_o), 32'h3F);

    // CTRL write with ignored upper bit
    step(2'b10, 8'h04, 32'hD2, "wr_ctrl1");
    check("en1",   32'(slv_en_o[1]),       32'h0);
    check("prio1", 32'(slv_prio_o[3:2]),   32'h1);
    check("len1",  32'(slv_pkglen_o[5:3]), 32'h2);
    step(2'b01, 8'h04, 0, "rb_ctrl1");  check("ctrl1_rb", cmd_data_o, 32'h52);

    // Threshold interrupt, set-wins-over-clear, then clear
    step(2'b10, 8'h40, 32'd10, "wr_thresh");
    step(2'b10, 8'h08, 32'h41, "wr_ctrl2");
    set_margin(2, 45);
    step(2'b00, 8'h00, 0, "m45");      check("irq_m45", 32'(irq_o), 32'h0);
    set_margin(2, 8);
    step(2'b00, 8'h00, 0, "m8");       check("irq_m8",  32'(irq_o), 32'h1);
    step(2'b01, 8'h44, 0, "rd_irq");   check("irqstat_set", cmd_data_o, 32'h4);
    step(2'b10, 8'h44, 32'h4, "w1c_held");
    step(2'b01, 8'h44, 0, "rd_irq2");  check("irqstat_held", cmd_data_o, 32'h4);
    set_margin(2, 20);
    step(2'b10, 8'h44, 32'h4, "w1c");  check("irq_clr", 32'(irq_o), 32'h0);
    step(2'b01, 8'h44, 0, "rd_irq3");  check("irqstat_clr", cmd_data_o, 32'h0);

    // Error cases
    step(2'b10, 8'h20, 32'hFF, "wr_stat");  check("err_wr_stat", 32'(cmd_err_o), 32'h1);
    step(2'b01, 8'h05, 0, "unaligned");     check("err_unal",    32'(cmd_err_o), 32'h1);
    step(2'b10, 8'h0C, 32'h0, "ctrl3");     check("err_ctrl3",   32'(cmd_err_o), 32'h1);
    step(2'b11, 8'h00, 0, "rsvd");          check("err_rsvd",    32'(cmd_err_o), 32'h1);
    step(2'b00, 8'h00, 0, "idle");          check("err_gone",    32'(cmd_err_o), 32'h0);
    check("data_kept", cmd_data_o, 32'h0);

    rand_phase(250, 1'b0);

    // Lock
    step(2'b10, 8'h00, 32'h07, "ctrl0_def");
    step(2'b10, 8'h48, 32'h1, "lock");
    step(2'b10, 8'h00, 32'h0, "wr_locked"); check("err_locked", 32'(cmd_err_o), 32'h1);
    step(2'b01, 8'h00, 0, "rd_locked");     check("ctrl0_locked", cmd_data_o, 32'h07);
    step(2'b10, 8'h08, 32'h41, "ctrl2_locked");
    step(2'b01, 8'h48, 0, "rd_lock");       check("lock_rb", cmd_data_o, 32'h1);
    step(2'b01, 8'h40, 0, "rd_thr");
    step(2'b10, 8'h44, 32'h7, "w1c_all");
    step(2'b01, 8'h44, 0, "rd_irq4");
    rand_phase(150, 1'b1);

    // Asynchronous reset between edges
    @(negedge clk_i);
    cmd_i = 2'b00;
    #2 rst_i = 1'b1;
    #1;
    check("arst_data", cmd_data_o, 32'h0);
    check("arst_err",  32'(cmd_err_o), 32'h0);
    check("arst_en",   32'(slv_en_o), 32'h7);
    check("arst_prio", 32'(slv_prio_o), 32'h3F);
    check("arst_len",  32'(slv_pkglen_o), 32'h0);
    check("arst_irq",  32'(irq_o), 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    step(2'b01, 8'h48, 0, "rd_lock_rst");  check("lock_rst", cmd_data_o, 32'h0);
    step(2'b01, 8'h00, 0, "rd_ctrl_rst");  check("ctrl0_rst2", cmd_data_o, 32'h07);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
